// File: rtl/vt_bus_pkg.sv
// Shared definitions for the VT52 register-bus Wishbone initiator:
// bus widths, FSM state type, wait-counter width and response error codes.
package vt_bus_pkg;

  localparam int WB_ADR_W = 16;
  localparam int WB_DAT_W = 16;
  localparam int WB_SEL_W = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic ERR_NONE  = 1'b0;
  localparam logic ERR_ABORT = 1'b1;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating wait-state counter; expired_o flags the ACTIVE cycle at whose
// closing edge the count reaches TIMEOUT.
module wb_timeout_cnt
  import vt_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = TIMEOUT[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LIMIT - 1'b1);

endmodule

// File: rtl/vt_wb_master.sv
// Single-transaction classic Wishbone initiator between the VT52 control FSM
// and the video-controller register slave; one command in, one response out.
module vt_wb_master
  import vt_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [WB_ADR_W-1:0] cmd_adr_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  input  logic                wb_ack_i
);

  state_e              state_q, state_d;
  logic [WB_ADR_W-1:0] adr_q, adr_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic                we_q, we_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic                cyc_q, cyc_d;
  logic                skip_q, skip_d;
  logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                cnt_clr, cnt_en, expired;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    sel_d     = sel_q;
    cyc_d     = cyc_q;
    skip_d    = skip_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          we_d    = cmd_we_i;
          sel_d   = cmd_we_i ? cmd_sel_i : 2'b11;
          skip_d  = cmd_we_i && (cmd_sel_i == 2'b00);
          cyc_d   = !skip_d;
          cnt_clr = 1'b1;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A write with no byte lanes spends one bus-less cycle here so its
        // response lands one cycle after acceptance.
        if (skip_q) begin
          skip_d    = 1'b0;
          rsp_dat_d = '0;
          rsp_err_d = ERR_ABORT;
          state_d   = ST_DONE;
        end else begin
          cnt_en = 1'b1;
          if (wb_ack_i) begin
            cyc_d     = 1'b0;
            rsp_dat_d = we_q ? '0 : wb_dat_i;
            rsp_err_d = ERR_NONE;
            state_d   = ST_DONE;
          end else if (expired) begin
            cyc_d     = 1'b0;
            rsp_dat_d = '0;
            rsp_err_d = ERR_ABORT;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      cyc_q     <= 1'b0;
      skip_q    <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      cyc_q     <= cyc_d;
      skip_q    <= skip_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_DONE);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;

endmodule
